dmem_responder: RTL



---
 rtl/dmem_responder.sv | 118 +++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM plus a 4-word MMIO window (cycle counter, LED, output FIFO, status).
// Optional build macro DMEM_BOUNDS_CHECK_EN drops and flags stores to unmapped words below the window.
module dmem_responder #(
   parameter int          ADDR_BITS  = 12,
   parameter int          FIFO_DEPTH = 4,
   parameter logic [31:0] MMIO_BASE  = 32'h0000_FFF0,
   parameter int          LED_W      = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [31:0]      address_dmem,
   input  logic [31:0]      data,
   input  logic             wren,
   output logic [31:0]      q_dmem,
   output logic [LED_W-1:0] led,
   output logic [31:0]      tx_data,
   output logic             tx_valid,
   input  logic             tx_ready
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [31:0]          ram [2**ADDR_BITS];
   logic [31:0]          fifo_mem [FIFO_DEPTH];
   logic [ADDR_BITS-1:0] ram_addr;
   logic [PTR_W-1:0]     rd_ptr, wr_ptr;
   logic [CNT_W-1:0]     count;
   logic [31:0]          cycle_cnt;
   logic [31:0]          status;
   logic                 overflow, oob;
   logic                 in_ram, ram_ok, oob_hit;
   logic                 sel_cnt, sel_led, sel_push, sel_stat;
   logic                 empty, full, pop, push_req, push_ok, push_drop, stat_wr;

   // Address decode
   always_comb begin
      in_ram   = address_dmem < MMIO_BASE;
      sel_cnt  = address_dmem == MMIO_BASE;
      sel_led  = address_dmem == MMIO_BASE + 32'd1;
      sel_push = address_dmem == MMIO_BASE + 32'd2;
      sel_stat = address_dmem == MMIO_BASE + 32'd3;
      ram_addr = address_dmem[ADDR_BITS-1:0];
`ifdef DMEM_BOUNDS_CHECK_EN
      ram_ok   = in_ram && (address_dmem < (32'd1 << ADDR_BITS));
      oob_hit  = in_ram && !ram_ok;
`else
      ram_ok   = in_ram;
      oob_hit  = 1'b0;
`endif
   end

   always_comb begin
      empty     = count == '0;
      full      = count == CNT_W'(FIFO_DEPTH);
      tx_valid  = !empty;
      tx_data   = empty ? 32'd0 : fifo_mem[rd_ptr];
      pop       = tx_valid && tx_ready;
      push_req  = wren && sel_push;
      // A full FIFO still takes a push when the head leaves in the same cycle.
      push_ok   = push_req && (!full || pop);
      push_drop = push_req && !push_ok;
      stat_wr   = wren && sel_stat;
   end

   always_comb begin
      status    = 32'd0;
      status[3:0] = 4'(count);
      status[5] = empty;
      status[6] = full;
      status[7] = overflow;
`ifdef DMEM_BOUNDS_CHECK_EN
      status[8] = oob;
`endif
   end

   // Combinational read; a same-cycle store is not yet visible.
   always_comb begin
      q_dmem = 32'd0;
      if (ram_ok)        q_dmem = ram[ram_addr];
      else if (sel_cnt)  q_dmem = cycle_cnt;
      else if (sel_led)  q_dmem[LED_W-1:0] = led;
      else if (sel_stat) q_dmem = status;
   end

   always_ff @(posedge clock) begin
      if (wren && ram_ok) ram[ram_addr] <= data;
      if (push_ok)        fifo_mem[wr_ptr] <= data;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cycle_cnt <= 32'd0;
         led       <= '0;
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         oob       <= 1'b0;
      end else begin
         cycle_cnt <= (wren && sel_cnt) ? data : cycle_cnt + 32'd1;
         if (wren && sel_led) led <= data[LED_W-1:0];
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop)     rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         // Set events take priority over write-1-to-clear.
         if (push_drop)                overflow <= 1'b1;
         else if (stat_wr && data[7])  overflow <= 1'b0;
         if (wren && oob_hit)          oob <= 1'b1;
         else if (stat_wr && data[8])  oob <= 1'b0;
      end
   end

endmodule
